// File: rtl/hex_display_ctrl_if.sv
// Load/value request channel into the display controller, with busy as the back-pressure flag.
// A request is one cycle with load=1 while busy=0. A load seen while busy=1 is dropped, not queued.
interface hex_display_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  load;
  logic                  mode;
  logic [DATA_WIDTH-1:0] value;
  logic                  busy;

  modport master (output load, output mode, output value, input busy);
  modport slave  (input load, input mode, input value, output busy);
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low 7-segment controller. Hex digits come from value nibbles; decimal uses a serial double-dabble converter.
// The display register adds enable, blink, overflow dashes and leading-zero blanking on top of the digit store.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clock,
  input  logic                    reset_s2,
  hex_display_ctrl_if.slave       bus,
  input  logic                    enable,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    overflow,
  output logic [1:0]              dbg_state
);

  localparam int BW  = 4 * NUM_DIGITS;
  localparam int CW  = $clog2(DATA_WIDTH + 1);
  localparam int BCW = $clog2(BLINK_DIV);
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_UPDATE  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [DATA_WIDTH-1:0]   r_value;
  logic                    r_mode;
  logic [DATA_WIDTH-1:0]   r_shreg;
  logic [BW-1:0]           r_bcd;
  logic [CW-1:0]           r_cnt;
  logic                    r_ovf_pend;
  logic [BW-1:0]           r_store;
  logic                    r_overflow;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic [BCW-1:0]          r_blink_cnt;
  logic                    r_phase;

  logic [BW-1:0]           w_bcd_adj;
  logic [BW-1:0]           w_hex_store;
  logic                    w_hex_ovf;
  logic [7*NUM_DIGITS-1:0] w_hex;
  logic                    w_capture;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  assign w_capture = (r_state == S_IDLE) && bus.load;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.load) w_state_next = bus.mode ? S_CONVERT : S_UPDATE;
      S_CONVERT: if (r_cnt == CW'(DATA_WIDTH - 1)) w_state_next = S_UPDATE;
      S_UPDATE:  w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset_s2) begin
    if (reset_s2) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Add-3 correction before the shift, so every digit stays a valid BCD digit after it doubles.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  assign w_hex_store = BW'(r_value);
  assign w_hex_ovf   = |(r_value >> BW);

  always_ff @(posedge clock or posedge reset_s2) begin
    if (reset_s2) begin
      r_value    <= '0;
      r_mode     <= 1'b0;
      r_shreg    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_store    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_capture) begin
        r_value    <= bus.value;
        r_mode     <= bus.mode;
        r_shreg    <= bus.value;
        r_bcd      <= '0;
        r_cnt      <= '0;
        r_ovf_pend <= 1'b0;
      end else if (r_state == S_CONVERT) begin
        r_bcd      <= {w_bcd_adj[BW-2:0], r_shreg[DATA_WIDTH-1]};
        r_shreg    <= r_shreg << 1;
        r_ovf_pend <= r_ovf_pend | w_bcd_adj[BW-1];
        r_cnt      <= r_cnt + CW'(1);
      end else if (r_state == S_UPDATE) begin
        r_store    <= r_mode ? r_bcd : w_hex_store;
        r_overflow <= r_mode ? r_ovf_pend : w_hex_ovf;
      end
    end
  end

  always_ff @(posedge clock or posedge reset_s2) begin
    if (reset_s2) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b1;
    end else if (r_blink_cnt == BCW'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      r_phase     <= ~r_phase;
    end else begin
      r_blink_cnt <= r_blink_cnt + BCW'(1);
    end
  end

  // Walk from the most significant digit down; blanking stops at the first nonzero digit.
  always_comb begin
    logic       w_lead;
    logic [3:0] w_digit;
    w_hex   = '1;
    w_lead  = 1'b1;
    w_digit = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_digit = r_store[4*i +: 4];
      if (!enable || (blink_en && !r_phase)) begin
        w_hex[7*i +: 7] = SEG_OFF;
      end else if (r_overflow) begin
        w_hex[7*i +: 7] = SEG_DASH;
      end else if (blank_lz && w_lead && (w_digit == 4'd0) && (i != 0)) begin
        w_hex[7*i +: 7] = SEG_OFF;
      end else begin
        w_hex[7*i +: 7] = seg7(w_digit);
        w_lead          = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset_s2) begin
    if (reset_s2) r_hex <= '1;
    else          r_hex <= w_hex;
  end

  assign hex       = r_hex;
  assign overflow  = r_overflow;
  assign bus.busy  = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule
